// File: rtl/ls_ifetch_arb_if.sv
// Bus bundle for the local-store read arbiter: fetch refill, LSU read and LS port.
interface ls_ifetch_arb_if #(
  parameter int LS_ADDR_W = 18
);
  logic                 fetch_req;
  logic [LS_ADDR_W-1:0] fetch_addr;
  logic                 fetch_busy;
  logic                 fetch_done;
  logic                 flush;
  logic                 fill_we;
  logic [1:0]           fill_idx;
  logic [127:0]         fill_data;
  logic                 lsu_req;
  logic [LS_ADDR_W-1:0] lsu_addr;
  logic                 lsu_gnt;
  logic                 lsu_rvalid;
  logic [127:0]         lsu_rdata;
  logic                 ls_rd_en;
  logic [LS_ADDR_W-1:0] ls_rd_addr;
  logic [127:0]         ls_rd_data;

  // Arbiter side
  modport slave (
    input  fetch_req, fetch_addr, flush, lsu_req, lsu_addr, ls_rd_data,
    output fetch_busy, fetch_done, fill_we, fill_idx, fill_data,
           lsu_gnt, lsu_rvalid, lsu_rdata, ls_rd_en, ls_rd_addr
  );

  // Requester / LS memory side
  modport master (
    output fetch_req, fetch_addr, flush, lsu_req, lsu_addr, ls_rd_data,
    input  fetch_busy, fetch_done, fill_we, fill_idx, fill_data,
           lsu_gnt, lsu_rvalid, lsu_rdata, ls_rd_en, ls_rd_addr
  );
endinterface

// File: rtl/ls_ifetch_arb.sv
// Local-store read-port arbiter: LSU reads vs. 64B instruction-line refills,
// with starvation guard, flush cancel and a tagged one-cycle return path.
module ls_ifetch_arb #(
  parameter int LS_ADDR_W  = 18,
  parameter int LINE_BEATS = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            reset,
  ls_ifetch_arb_if.slave  bus
);
  localparam int BW       = $clog2(LINE_BEATS);
  localparam int LINE_LSB = 4 + BW;
  localparam int SW       = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                      state_q, state_d;
  logic                        pend_q, pend_d;
  logic [LS_ADDR_W-1:LINE_LSB] base_q, base_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic [SW-1:0]               starve_q, starve_d;
  logic                        busy_q, busy_d;
  logic                        tag_v_q, tag_v_d;
  logic                        tag_fetch_q, tag_fetch_d;
  logic [BW-1:0]               tag_beat_q, tag_beat_d;

  logic                        rd_en;
  logic [LS_ADDR_W-1:0]        rd_addr;
  logic                        gnt;
  logic                        issue_fetch;
  logic [BW-1:0]               issue_beat;
  logic                        ret_lsu;
  logic                        ret_fill;
  logic                        done;

  logic unused_bits;
  assign unused_bits = ^{bus.lsu_addr[3:0], bus.fetch_addr[LINE_LSB-1:0]};

  // State register and return tag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      base_q      <= '0;
      beat_q      <= '0;
      starve_q    <= '0;
      busy_q      <= 1'b0;
      tag_v_q     <= 1'b0;
      tag_fetch_q <= 1'b0;
      tag_beat_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      base_q      <= base_d;
      beat_q      <= beat_d;
      starve_q    <= starve_d;
      busy_q      <= busy_d;
      tag_v_q     <= tag_v_d;
      tag_fetch_q <= tag_fetch_d;
      tag_beat_q  <= tag_beat_d;
    end
  end

  // Arbitration, beat sequencing, flush cancel and return routing
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    base_d      = base_q;
    beat_d      = beat_q;
    starve_d    = starve_q;
    busy_d      = busy_q;
    rd_en       = 1'b0;
    rd_addr     = '0;
    gnt         = 1'b0;
    issue_fetch = 1'b0;
    issue_beat  = '0;

    // Outputs are forced low during the reset cycle, dropping any return data.
    ret_lsu  = tag_v_q & ~tag_fetch_q & ~reset;
    ret_fill = tag_v_q &  tag_fetch_q & ~reset;
    done     = ret_fill && (tag_beat_q == BW'(LINE_BEATS - 1));
    if (done) busy_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_q && !bus.flush &&
            (!bus.lsu_req || starve_q == SW'(STARVE_MAX))) begin
          issue_fetch = 1'b1;
          issue_beat  = '0;
          beat_d      = BW'(1);
          state_d     = ISSUE;
          pend_d      = 1'b0;
        end else begin
          if (bus.lsu_req) begin
            gnt     = 1'b1;
            rd_en   = 1'b1;
            rd_addr = {bus.lsu_addr[LS_ADDR_W-1:4], 4'b0};
            if (pend_q && starve_q != SW'(STARVE_MAX))
              starve_d = starve_q + SW'(1);
          end
          if (!pend_q && bus.fetch_req && !bus.flush) begin
            pend_d = 1'b1;
            base_d = bus.fetch_addr[LS_ADDR_W-1:LINE_LSB];
            busy_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        issue_fetch = 1'b1;
        issue_beat  = beat_q;
        beat_d      = beat_q + BW'(1);
        if (beat_q == BW'(LINE_BEATS - 1)) begin
          state_d = IDLE;
          beat_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue_fetch) begin
      rd_en   = 1'b1;
      rd_addr = {base_q, issue_beat, 4'b0};
    end

    // A flushed beat may still be on the LS port this cycle, but its tag is dropped.
    if (bus.flush) begin
      pend_d  = 1'b0;
      busy_d  = 1'b0;
      state_d = IDLE;
      beat_d  = '0;
    end
    if (!pend_d) starve_d = '0;

    if (reset) begin
      rd_en   = 1'b0;
      rd_addr = '0;
      gnt     = 1'b0;
    end

    tag_v_d     = rd_en & ~(issue_fetch & bus.flush);
    tag_fetch_d = issue_fetch;
    tag_beat_d  = issue_beat;
  end

  assign bus.ls_rd_en   = rd_en;
  assign bus.ls_rd_addr = rd_addr;
  assign bus.lsu_gnt    = gnt;
  assign bus.lsu_rvalid = ret_lsu;
  assign bus.lsu_rdata  = ret_lsu ? bus.ls_rd_data : '0;
  assign bus.fill_we    = ret_fill;
  assign bus.fill_idx   = ret_fill ? 2'(tag_beat_q) : 2'b0;
  assign bus.fill_data  = ret_fill ? bus.ls_rd_data : '0;
  assign bus.fetch_done = done;
  assign bus.fetch_busy = busy_q & ~reset;
endmodule

// File: tb/tb_ls_ifetch_arb.sv
// Testbench for ls_ifetch_arb: directed vector table, corner-case sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_ls_ifetch_arb;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ls_ifetch_arb_if #(.LS_ADDR_W(18)) bus ();

  ls_ifetch_arb #(.LS_ADDR_W(18), .LINE_BEATS(4), .STARVE_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [127:0] mem(input logic [17:0] a);
    logic [31:0] x;
    x = {14'b0, a};
    return {x * 32'h9E3779B1, ~x, x + 32'h01234567, x ^ 32'h5A5A5A5A};
  endfunction

  // LS memory: data for the address read one cycle earlier
  logic [17:0] mem_addr_q = '0;
  always @(posedge clk) if (bus.ls_rd_en) mem_addr_q <= bus.ls_rd_addr;
  assign bus.ls_rd_data = mem(mem_addr_q);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: pending request, beats still to issue, one-deep return slot
  bit          m_pend, m_busy, m_rv, m_rfetch;
  int          m_left, m_starve, m_rbeat;
  logic [17:0] m_line = '0, m_raddr = '0;

  typedef struct packed {
    logic         rd_en;
    logic [17:0]  rd_addr;
    logic         gnt;
    logic         rvalid;
    logic [127:0] rdata;
    logic         fill_we;
    logic [1:0]   fill_idx;
    logic [127:0] fill_data;
    logic         done;
    logic         busy;
  } exp_t;

  task automatic model_step();
    exp_t e;
    bit iss_f, iss_l, acc;
    logic [17:0] a;
    int b;
    bit n_pend, n_busy;
    int n_left, n_starve;
    logic [17:0] n_line;
    e = '0; iss_f = 0; iss_l = 0; acc = 0; a = '0; b = 0;
    if (reset) begin
      m_pend = 0; m_busy = 0; m_rv = 0; m_left = 0; m_starve = 0;
    end else begin
      n_pend = m_pend; n_busy = m_busy; n_left = m_left; n_starve = m_starve; n_line = m_line;
      e.rvalid  = m_rv && !m_rfetch;
      if (e.rvalid) e.rdata = mem(m_raddr);
      e.fill_we = m_rv && m_rfetch;
      if (e.fill_we) begin
        e.fill_idx  = 2'(m_rbeat);
        e.fill_data = mem(m_raddr);
      end
      e.done = e.fill_we && m_rbeat == 3;
      e.busy = m_busy;
      if (m_left > 0) begin
        iss_f = 1; b = 4 - m_left; n_left = m_left - 1;
      end else if (m_pend && !bus.flush && (!bus.lsu_req || m_starve == 8)) begin
        iss_f = 1; b = 0; n_left = 3; n_pend = 0;
      end else begin
        if (bus.lsu_req) begin
          iss_l = 1;
          a = bus.lsu_addr & ~18'hF;
          if (m_pend && !bus.flush && m_starve < 8) n_starve = m_starve + 1;
        end
        if (!m_pend && bus.fetch_req && !bus.flush) begin
          acc = 1; n_pend = 1; n_line = bus.fetch_addr & ~18'h3F;
        end
      end
      if (iss_f) a = m_line + 18'(16 * b);
      if (e.done) n_busy = 0;
      if (acc) n_busy = 1;
      if (bus.flush) begin n_pend = 0; n_left = 0; n_busy = 0; end
      if (!n_pend) n_starve = 0;
      e.rd_en = iss_f || iss_l;
      e.rd_addr = a;
      e.gnt = iss_l;
      m_rv = (iss_f && !bus.flush) || iss_l;
      m_rfetch = iss_f; m_rbeat = b; m_raddr = a;
      m_pend = n_pend; m_busy = n_busy; m_left = n_left; m_starve = n_starve; m_line = n_line;
    end
    chk("m.rd_en",     128'(bus.ls_rd_en),   128'(e.rd_en));
    chk("m.rd_addr",   128'(bus.ls_rd_addr), 128'(e.rd_addr));
    chk("m.gnt",       128'(bus.lsu_gnt),    128'(e.gnt));
    chk("m.rvalid",    128'(bus.lsu_rvalid), 128'(e.rvalid));
    chk("m.rdata",     bus.lsu_rdata,        e.rdata);
    chk("m.fill_we",   128'(bus.fill_we),    128'(e.fill_we));
    chk("m.fill_idx",  128'(bus.fill_idx),   128'(e.fill_idx));
    chk("m.fill_data", bus.fill_data,        e.fill_data);
    chk("m.done",      128'(bus.fetch_done), 128'(e.done));
    chk("m.busy",      128'(bus.fetch_busy), 128'(e.busy));
  endtask

  task automatic drive(input bit r, input bit fr, input logic [17:0] fa,
                       input bit fl, input bit lr, input logic [17:0] la);
    reset = r; bus.fetch_req = fr; bus.fetch_addr = fa;
    bus.flush = fl; bus.lsu_req = lr; bus.lsu_addr = la;
  endtask

  task automatic settle();
    #3;
    model_step();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk(name, 128'({bus.ls_rd_en, bus.lsu_gnt, bus.lsu_rvalid, bus.fill_we, bus.fetch_done,
                    bus.fetch_busy, bus.fill_idx, bus.ls_rd_addr}) | bus.lsu_rdata | bus.fill_data,
        128'(0));
  endtask

  typedef struct {
    bit fr; logic [17:0] fa; bit fl; bit lr; logic [17:0] la;
    bit e_rden; logic [17:0] e_addr; bit e_gnt; bit e_fwe; logic [1:0] e_idx;
    bit e_done; bit e_busy; bit e_rv; logic [17:0] e_daddr;
  } vec_t;

  vec_t tv[19];

  initial begin
    // fr fa fl lr la | rden addr gnt fwe idx done busy rv daddr
    // idle refill of line 0x140
    tv[0]  = '{1, 18'h00140, 0, 0, 18'h0, 0, 18'h0,     0, 0, 2'd0, 0, 0, 0, 18'h0};
    tv[1]  = '{0, 18'h0,     0, 0, 18'h0, 1, 18'h00140, 0, 0, 2'd0, 0, 1, 0, 18'h0};
    tv[2]  = '{0, 18'h0,     0, 0, 18'h0, 1, 18'h00150, 0, 1, 2'd0, 0, 1, 0, 18'h00140};
    tv[3]  = '{0, 18'h0,     0, 0, 18'h0, 1, 18'h00160, 0, 1, 2'd1, 0, 1, 0, 18'h00150};
    tv[4]  = '{0, 18'h0,     0, 0, 18'h0, 1, 18'h00170, 0, 1, 2'd2, 0, 1, 0, 18'h00160};
    tv[5]  = '{0, 18'h0,     0, 0, 18'h0, 0, 18'h0,     0, 1, 2'd3, 1, 1, 0, 18'h00170};
    tv[6]  = '{0, 18'h0,     0, 0, 18'h0, 0, 18'h0,     0, 0, 2'd0, 0, 0, 0, 18'h0};
    // LSU grant the cycle before beat 0 of a top-of-LS line; fetch_addr low bits ignored
    tv[7]  = '{1, 18'h3FFC7, 0, 1, 18'h0123F, 1, 18'h01230, 1, 0, 2'd0, 0, 0, 0, 18'h0};
    tv[8]  = '{0, 18'h0,     0, 0, 18'h0, 1, 18'h3FFC0, 0, 0, 2'd0, 0, 1, 1, 18'h01230};
    tv[9]  = '{0, 18'h0,     0, 0, 18'h0, 1, 18'h3FFD0, 0, 1, 2'd0, 0, 1, 0, 18'h3FFC0};
    tv[10] = '{0, 18'h0,     0, 0, 18'h0, 1, 18'h3FFE0, 0, 1, 2'd1, 0, 1, 0, 18'h3FFD0};
    tv[11] = '{0, 18'h0,     0, 0, 18'h0, 1, 18'h3FFF0, 0, 1, 2'd2, 0, 1, 0, 18'h3FFE0};
    tv[12] = '{0, 18'h0,     0, 0, 18'h0, 0, 18'h0,     0, 1, 2'd3, 1, 1, 0, 18'h3FFF0};
    tv[13] = '{0, 18'h0,     0, 0, 18'h0, 0, 18'h0,     0, 0, 2'd0, 0, 0, 0, 18'h0};
    // flush in the cycle beat 1 is issued
    tv[14] = '{1, 18'h00A80, 0, 0, 18'h0, 0, 18'h0,     0, 0, 2'd0, 0, 0, 0, 18'h0};
    tv[15] = '{0, 18'h0,     0, 0, 18'h0, 1, 18'h00A80, 0, 0, 2'd0, 0, 1, 0, 18'h0};
    tv[16] = '{0, 18'h0,     1, 0, 18'h0, 1, 18'h00A90, 0, 1, 2'd0, 0, 1, 0, 18'h00A80};
    tv[17] = '{0, 18'h0,     0, 0, 18'h0, 0, 18'h0,     0, 0, 2'd0, 0, 0, 0, 18'h0};
    tv[18] = '{0, 18'h0,     0, 0, 18'h0, 0, 18'h0,     0, 0, 2'd0, 0, 0, 0, 18'h0};

    // reset with an LSU request present: no grant, all outputs low
    drive(1, 1, 18'h00140, 0, 1, 18'h00100);
    advance();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_zero($sformatf("reset%0d", i));
      advance();
    end

    // directed vector table
    for (int i = 0; i < $size(tv); i++) begin
      drive(0, tv[i].fr, tv[i].fa, tv[i].fl, tv[i].lr, tv[i].la);
      settle();
      chk($sformatf("vec%0d.rd_en", i),   128'(bus.ls_rd_en),   128'(tv[i].e_rden));
      chk($sformatf("vec%0d.rd_addr", i), 128'(bus.ls_rd_addr), 128'(tv[i].e_addr));
      chk($sformatf("vec%0d.gnt", i),     128'(bus.lsu_gnt),    128'(tv[i].e_gnt));
      chk($sformatf("vec%0d.fill_we", i), 128'(bus.fill_we),    128'(tv[i].e_fwe));
      chk($sformatf("vec%0d.fill_idx", i), 128'(bus.fill_idx),  128'(tv[i].e_idx));
      chk($sformatf("vec%0d.done", i),    128'(bus.fetch_done), 128'(tv[i].e_done));
      chk($sformatf("vec%0d.busy", i),    128'(bus.fetch_busy), 128'(tv[i].e_busy));
      chk($sformatf("vec%0d.rvalid", i),  128'(bus.lsu_rvalid), 128'(tv[i].e_rv));
      if (tv[i].e_fwe) chk($sformatf("vec%0d.fill_data", i), bus.fill_data, mem(tv[i].e_daddr));
      if (tv[i].e_rv)  chk($sformatf("vec%0d.lsu_rdata", i), bus.lsu_rdata, mem(tv[i].e_daddr));
      advance();
    end

    // starvation: LSU held continuously while a refill waits
    begin
      int cnt;
      bit hit;
      cnt = 0; hit = 0;
      drive(0, 1, 18'h00200, 0, 1, 18'($urandom));
      settle();
      chk("starve.accept_gnt", 128'(bus.lsu_gnt), 128'(1));
      advance();
      for (int i = 0; i < 20; i++) begin
        drive(0, 0, 18'h0, 0, 1, 18'($urandom));
        settle();
        if (bus.ls_rd_en && !bus.lsu_gnt) begin hit = 1; break; end
        if (bus.lsu_gnt) cnt++;
        advance();
      end
      chk("starve.issue_seen", 128'(hit), 128'(1));
      chk("starve.grants", 128'(cnt), 128'(8));
      chk("starve.beat0", 128'(bus.ls_rd_addr), 128'(18'h00200));
      for (int b = 1; b < 4; b++) begin
        advance();
        drive(0, 0, 18'h0, 0, 1, 18'($urandom));
        settle();
        chk($sformatf("starve.beat%0d_addr", b), 128'(bus.ls_rd_addr), 128'(18'h00200 + 18'(16 * b)));
        chk($sformatf("starve.beat%0d_gnt", b), 128'(bus.lsu_gnt), 128'(0));
      end
      advance();
      drive(0, 0, 18'h0, 0, 1, 18'($urandom));
      settle();
      chk("starve.resume_gnt", 128'(bus.lsu_gnt), 128'(1));
      advance();
      drive(0, 0, 18'h0, 0, 0, 18'h0);
      for (int i = 0; i < 3; i++) begin settle(); advance(); end
    end

    // reset mid-refill: asserted in the cycle after beat 2 issue
    begin
      int fwe, dn;
      fwe = 0; dn = 0;
      drive(0, 1, 18'h00300, 0, 0, 18'h0);
      settle(); advance();
      drive(0, 0, 18'h0, 0, 0, 18'h0);
      for (int i = 0; i < 3; i++) begin settle(); advance(); end
      drive(1, 0, 18'h0, 0, 0, 18'h0);
      settle();
      chk_zero("rstmid.reset_cycle");
      advance();
      drive(0, 1, 18'h00400, 0, 0, 18'h0);
      settle();
      chk_zero("rstmid.after_reset");
      advance();
      drive(0, 0, 18'h0, 0, 0, 18'h0);
      for (int i = 0; i < 7; i++) begin
        settle();
        if (bus.fill_we) begin
          chk($sformatf("rstmid.data%0d", fwe), bus.fill_data, mem(18'h00400 + 18'(16 * fwe)));
          fwe++;
        end
        if (bus.fetch_done) dn++;
        advance();
      end
      chk("rstmid.fill_count", 128'(fwe), 128'(4));
      chk("rstmid.done_count", 128'(dn), 128'(1));
    end

    // back-to-back refills with fetch_req held across fetch_done
    begin
      int beats, dn, second_at;
      beats = 0; dn = 0; second_at = -1;
      for (int i = 0; i < 12; i++) begin
        drive(0, i < 6, (i == 0) ? 18'h00500 : 18'h00600, 0, 0, 18'h0);
        settle();
        if (bus.ls_rd_en && !bus.lsu_gnt) begin
          beats++;
          if (bus.ls_rd_addr == 18'h00600 && second_at < 0) second_at = i;
        end
        if (bus.fetch_done) dn++;
        advance();
      end
      chk("b2b.beats", 128'(beats), 128'(8));
      chk("b2b.dones", 128'(dn), 128'(2));
      chk("b2b.second_issue_cycle", 128'(second_at), 128'(6));
    end

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, 18'($urandom),
            $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1, 18'($urandom));
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ls_ifetch_arb.md
Name: ls_ifetch_arb

Overview:
Arbitrates the single local-store (LS) read port between the load/store unit and instruction-line refills for the fetch stage's 64B instruction line buffer. On a fetch refill it sequences the 64B line as 4 back-to-back 128-bit quadword reads and writes each returned beat into the line buffer. LSU reads have default priority. A starvation counter guarantees refill progress. A flush (branch redirect) cancels an in-flight refill.

Parameters:
LS_ADDR_W, 18, LS byte-address width (256KB LS)
LINE_BEATS, 4, quadword beats per instruction line (64B / 16B)
STARVE_MAX, 8, consecutive LSU grants tolerated while a refill waits

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
fetch_req  input  1  level; fetch stage requests a line refill
fetch_addr  input  LS_ADDR_W  line byte address; bits [5:0] ignored
fetch_busy  output  1  refill accepted and not yet completed or cancelled
fetch_done  output  1  one-cycle pulse: final beat written
flush  input  1  cancel refill (branch redirect)
fill_we  output  1  line-buffer write strobe
fill_idx  output  2  beat index 0..3 (words 4*idx..4*idx+3)
fill_data  output  128  beat data
lsu_req  input  1  LSU read request, held until granted
lsu_addr  input  LS_ADDR_W  LSU quadword byte address; bits [3:0] ignored
lsu_gnt  output  1  LSU request issued to LS this cycle
lsu_rvalid  output  1  LSU read data valid
lsu_rdata  output  128  LSU read data
ls_rd_en  output  1  LS read strobe
ls_rd_addr  output  LS_ADDR_W  LS read byte address, 16B aligned
ls_rd_data  input  128  LS data; valid exactly 1 cycle after ls_rd_en

Behaviour:
- Reset (synchronous, any state, including mid-refill): state=IDLE; pending=0; starve_cnt=0; return tag cleared. All outputs 0. Data returning in the cycle after reset is dropped.
- Refill accept:
  - In IDLE with pending=0 and fetch_req=1: latch fetch_addr[LS_ADDR_W-1:6] as line base; pending=1.
  - fetch_busy=1 from the next cycle.
  - fetch_req is ignored while pending or while not in IDLE.
- IDLE arbitration, evaluated every cycle (combinational grant):
  - pending && (!lsu_req || starve_cnt==STARVE_MAX): enter ISSUE. Beat 0 is issued in the same cycle; pending=0; starve_cnt=0; lsu_gnt=0.
  - else if lsu_req: lsu_gnt=1, ls_rd_en=1, ls_rd_addr={lsu_addr[..:4],4'b0}. If pending, starve_cnt++ (saturating at STARVE_MAX).
  - else: no LS access.
- ISSUE state:
  - Beat counter b=0..LINE_BEATS-1, one beat per cycle, no bubbles.
  - ls_rd_en=1; ls_rd_addr = base + 16*b.
  - lsu_gnt=0 throughout.
  - After beat LINE_BEATS-1 is issued, return to IDLE. A new grant is legal in that next cycle.
- Return path, independent of state:
  - A registered tag {valid, src, beat} accompanies each issued read.
  - src=LSU: next cycle lsu_rvalid=1, lsu_rdata=ls_rd_data.
  - src=FETCH: next cycle fill_we=1, fill_idx=beat, fill_data=ls_rd_data.
  - fetch_done=1 in the same cycle as fill_we for beat LINE_BEATS-1. fetch_busy drops the following cycle.
- Refill latency: with no LSU contention, accept at cycle N gives issues at N+1..N+4, fill_we at N+2..N+5, and fetch_done at N+5.
- flush:
  - flush=1 in any cycle clears pending and any FETCH-tagged return in flight (its fill_we is suppressed), and forces IDLE next cycle.
  - No further fetch beats are issued. fetch_done is never asserted for a cancelled refill. fetch_busy=0 next cycle.
  - An in-flight LSU return is unaffected.
  - flush together with fetch_req: flush wins; the request is not accepted that cycle.
  - flush in IDLE with nothing pending: no effect.
- Address arithmetic: base+16*b never carries out of the 64B line. The LS address wraps modulo 2^LS_ADDR_W.
- starve_cnt only counts while pending=1 and is held at 0 otherwise.

Test Plan:
- Idle refill: fetch_req=1, fetch_addr=0x00140, lsu_req=0 -> ls_rd_addr 0x140,0x150,0x160,0x170 on consecutive cycles; fill_idx 0..3 with matching data one cycle later; single fetch_done pulse with fill_idx=3.
- LSU priority and starvation: lsu_req held 1 continuously, refill pending -> exactly 8 lsu_gnt pulses, then 4 refill beats with lsu_gnt=0, then LSU grants resume.
- Interleave: an LSU read granted the cycle before refill issue -> lsu_rvalid returns in the cycle of beat 0 issue; no data cross-routed between lsu_rdata and fill_data.
- Flush mid-refill: flush asserted in the cycle beat 1 is issued -> fill_we for beat 0 only; beat 1 write suppressed; no beat 2/3 issue; no fetch_done; fetch_busy=0 next cycle.
- Reset mid-refill: reset in the cycle after beat 2 issue -> all outputs 0 next cycle, beat-2 data dropped; a new refill after reset completes normally.
- Back-to-back: fetch_req held high across fetch_done -> second refill accepted in the cycle after return to IDLE; total 8 beats, 2 fetch_done pulses.
